// File: rtl/spi_slave_if.sv
// SPI bus bundle between an external master and spi_slave.
// csN is active-low chip select; sck/csN/mosi are asynchronous to the slave's system clock.
interface spi_slave_if;
    logic sck;
    logic csN;
    logic mosi;
    logic miso;

    modport master (output sck, output csN, output mosi, input miso);
    modport slave  (input sck, input csN, input mosi, output miso);
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four clock modes, oversampled on the system clock.
// Receives MSB-first bytes on MOSI and returns a captured parallel byte on MISO.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ckp,
    input  logic       i_cph,
    input  logic [7:0] i_dataInput,
    output logic [7:0] o_dataOut,
    output logic       o_valid,
    output logic       o_busy,
    spi_slave_if.slave bus
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [SYNC_STAGES-1:0] r_sckSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_sckPrev;
    logic                   r_csPrev;

    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_dataOut;
    logic [2:0] r_bitCount;
    logic       r_valid;
    logic       r_busy;
    logic       r_skipShift;

    logic w_sck;
    logic w_cs;
    logic w_mosi;
    logic w_lead;
    logic w_trail;
    logic w_sampleEdge;
    logic w_shiftEdge;
    logic w_csFall;
    logic w_csRise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sckSync  <= '0;
            r_csSync   <= '1;
            r_mosiSync <= '0;
            r_sckPrev  <= 1'b0;
            r_csPrev   <= 1'b1;
        end else begin
            r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], bus.sck};
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], bus.csN};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi};
            r_sckPrev  <= w_sck;
            r_csPrev   <= w_cs;
        end
    end

    assign w_sck  = r_sckSync[SYNC_STAGES-1];
    assign w_cs   = r_csSync[SYNC_STAGES-1];
    assign w_mosi = r_mosiSync[SYNC_STAGES-1];

    assign w_lead       = (r_sckPrev == i_ckp) && (w_sck != i_ckp);
    assign w_trail      = (r_sckPrev != i_ckp) && (w_sck == i_ckp);
    assign w_sampleEdge = i_cph ? w_trail : w_lead;
    assign w_shiftEdge  = i_cph ? w_lead : w_trail;
    assign w_csFall     = r_csPrev & ~w_cs;
    assign w_csRise     = ~r_csPrev & w_cs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_csFall) w_stateNext = ACTIVE;
            ACTIVE:  if (w_csRise) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // A freshly loaded byte must keep its MSB through the first shift edge
    // that precedes its first sample, hence the one-shot skip flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx        <= 8'h00;
            r_rx        <= 8'h00;
            r_dataOut   <= 8'h00;
            r_bitCount  <= 3'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_skipShift <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_busy  <= (w_stateNext == ACTIVE);
            if (r_state == IDLE) begin
                if (w_csFall) begin
                    r_tx        <= i_dataInput;
                    r_rx        <= 8'h00;
                    r_bitCount  <= 3'd0;
                    r_skipShift <= i_cph;
                end
            end else if (w_sampleEdge) begin
                r_rx       <= {r_rx[6:0], w_mosi};
                r_bitCount <= r_bitCount + 3'd1;
                if (r_bitCount == 3'd7) begin
                    r_dataOut   <= {r_rx[6:0], w_mosi};
                    r_valid     <= 1'b1;
                    r_tx        <= i_dataInput;
                    r_skipShift <= 1'b1;
                end
            end else if (w_shiftEdge) begin
                if (r_skipShift) begin
                    r_skipShift <= 1'b0;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign bus.miso  = (r_state == ACTIVE) ? r_tx[7] : 1'b0;
    assign o_dataOut = r_dataOut;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of CLK-domain synchronizer flops on SCK, CS and MOSI; legal values are 2 and 3.
REQ-002 CLK  input  1  system clock; all state SHALL update on the CLK rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-low.
REQ-004 CKP  input  1  SCK idle level (clock polarity); quasi-static, changed only while CS=1.
REQ-005 CPH  input  1  clock phase; 0 = sample on leading SCK edge, 1 = sample on trailing edge; quasi-static.
REQ-006 SCK  input  1  serial clock from master, asynchronous to CLK, period >= 8 CLK.
REQ-007 CS  input  1  chip select, active-low.
REQ-008 MOSI  input  1  serial data from master, MSB first.
REQ-009 DATAINPUT  input  8  byte returned to master; captured at each byte start.
REQ-010 MISO  output  1  serial data to master, MSB first.
REQ-011 DATAOUT  output  8  last completely received byte.
REQ-012 VALID  output  1  one-CLK pulse marking a DATAOUT update.
REQ-013 BUSY  output  1  high while a transfer is selected (state ACTIVE).

Function
REQ-014 SCK, CS and MOSI SHALL pass through SYNC_STAGES flops before any use; edges SHALL be detected on the synchronized SCK against its previous value.
REQ-015 Leading edge = synchronized SCK leaving level CKP; trailing edge = returning to CKP.
REQ-016 Sample edge = leading if CPH=0, trailing if CPH=1; shift edge = the other one.
REQ-017 States: IDLE, ACTIVE. IDLE->ACTIVE on synchronized CS falling; ACTIVE->IDLE on synchronized CS rising; no other transitions.
REQ-018 On IDLE->ACTIVE: tx shift register <= DATAINPUT, bit counter <= 0, rx shift register <= 0.
REQ-019 MISO SHALL be tx shift register bit 7 while ACTIVE, and 0 while IDLE.
REQ-020 On each sample edge in ACTIVE: rx <= {rx[6:0], MOSI_sync}, bit counter +1 (3-bit, wraps 7->0).
REQ-021 On each shift edge in ACTIVE: tx <= {tx[6:0], 0}; exception CPH=1: the first leading edge of a byte SHALL NOT shift (MSB already presented).
REQ-022 On the sample edge where the counter wraps 7->0: DATAOUT <= completed byte on the next CLK edge, VALID=1 for exactly that cycle, tx <= DATAINPUT (back-to-back byte, CS still low).
REQ-023 Latency: VALID SHALL assert SYNC_STAGES+1 CLK cycles after the 8th sample edge of SCK at the pin.
REQ-024 CS rising mid-byte (counter != 0): transfer aborted, no VALID, DATAOUT unchanged, partial bits discarded.
REQ-025 CS rising coincident with the 8th sample edge: the byte SHALL complete (VALID asserted) before returning to IDLE.
REQ-026 SCK edges while IDLE SHALL be ignored; CS falling while ACTIVE cannot occur and needs no handling.
REQ-027 BUSY = (state == ACTIVE), registered.

Reset
REQ-028 RESET=0 SHALL immediately force: state IDLE, MISO=0, DATAOUT=8'h00, VALID=0, BUSY=0, counter=0, tx=rx=8'h00, all synchronizer flops to CS=1, SCK=CKP level 0, MOSI=0.
REQ-029 Reset asserted mid-byte SHALL discard the byte; after RESET=1 the block SHALL wait for a fresh CS falling edge.
REQ-030 Master convention: CS low >= 4 CLK before the first SCK edge and held >= 4 CLK after the last.

Verification
REQ-031 Mode 0 (CKP=0,CPH=0), DATAINPUT=8'hA5, master sends 8'h3C -> DATAOUT=8'h3C, one VALID pulse, MISO bits 1,0,1,0,0,1,0,1.
REQ-032 Mode 3 (CKP=1,CPH=1), DATAINPUT=8'hFF, master sends 8'h81 -> DATAOUT=8'h81, MISO all 1 on the 8 sample edges.
REQ-033 Modes 1 and 2, master sends 8'h5A each -> DATAOUT=8'h5A, exactly one VALID per byte.
REQ-034 Back-to-back, CS low for 16 SCK cycles, master sends 8'h12 then 8'h34 -> two VALID pulses, DATAOUT 8'h12 then 8'h34; DATAINPUT change between bytes seen on MISO for byte 2.
REQ-035 CS raised after 5 bits -> no VALID, DATAOUT holds previous value, BUSY drops; next full byte 8'hC3 received correctly.
REQ-036 RESET=0 after 4 bits of 8'hF0 -> all outputs to reset values within same cycle; after release, full byte 8'h0F received correctly.
